// File: rtl/sound_pkg.sv
// Shared types, note tables and helpers for the sound sequencer.
// Event 0 is the highest priority; a note count of 0 disables an event.
package sound_pkg;

  localparam int EVT_COUNT  = 4;
  localparam int NOTE_SLOTS = 4;
  localparam int PS_W       = 32;
  localparam int DUR_BITS   = 4;
  localparam int NCNT_W     = $clog2(NOTE_SLOTS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PS_W-1:0]     prescale;
    logic [DUR_BITS-1:0] dur;
  } note_t;

  localparam logic [NCNT_W-1:0] NOTE_CNT [EVT_COUNT] = '{
    NCNT_W'(3), NCNT_W'(3), NCNT_W'(1), NCNT_W'(1)
  };

  localparam note_t NOTE_TABLE [EVT_COUNT][NOTE_SLOTS] = '{
    '{'{32'd746,    4'd2}, '{32'd627,  4'd4}, '{32'd498,  4'd8}, '{32'd0, 4'd0}},
    '{'{32'd3986,   4'd2}, '{32'd4740, 4'd4}, '{32'd5972, 4'd8}, '{32'd0, 4'd0}},
    '{'{32'd627,    4'd2}, '{32'd0,    4'd0}, '{32'd0,    4'd0}, '{32'd0, 4'd0}},
    '{'{32'd160000, 4'd2}, '{32'd0,    4'd0}, '{32'd0,    4'd0}, '{32'd0, 4'd0}}
  };

  // A zero-length note still plays for one tick.
  function automatic logic [DUR_BITS-1:0] noteTicks(input note_t n);
    return (n.dur == '0) ? DUR_BITS'(1) : n.dur;
  endfunction

endpackage

// File: rtl/sound_tick_gen.sv
// Divides clk down to a one-cycle tick every TICK_CYCLES cycles.
// A synchronous restart realigns the phase so each note starts a fresh tick period.
module sound_tick_gen #(
  parameter int TICK_CYCLES = 6_250_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Priority-arbitrated multi-note sound sequencer driving a tone generator.
// Lower event index wins; lower-priority requests wait in a pending mask.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int NUM_EVENTS  = EVT_COUNT,
  parameter int MAX_NOTES   = NOTE_SLOTS,
  parameter int PRESCALE_W  = PS_W,
  parameter int DUR_W       = DUR_BITS,
  parameter int TICK_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 0,
  parameter int RETRIGGER   = 1
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [NUM_EVENTS-1:0]         event_req,
  input  logic                          mute,
  output logic                          enable_sound,
  output logic [PRESCALE_W-1:0]         pre_scale_value,
  output logic [$clog2(NUM_EVENTS)-1:0] active_event,
  output logic                          busy
);

  localparam int EVT_W = $clog2(NUM_EVENTS);
  localparam int IDX_W = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);

  state_t                state, stateN;
  logic [EVT_W-1:0]      activeEvt, activeEvtN;
  logic [IDX_W-1:0]      noteIdx, noteIdxN;
  logic [DUR_W-1:0]      durCnt, durCntN;
  logic [GAP_W-1:0]      gapCnt, gapCntN;
  logic [NUM_EVENTS-1:0] pending, pendingN;
  logic [PRESCALE_W-1:0] prescale, prescaleN;
  logic                  playQ, playQN;
  logic                  busyQ, busyQN;

  logic [NUM_EVENTS-1:0] enMask, cand, bestOh, actOh;
  logic [EVT_W-1:0]      best, startEvt;
  logic [IDX_W-1:0]      startIdx;
  logic                  anyCand, startNote, lastNote, tick;

  sound_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) uTickGen (
    .clk     (clk),
    .resetN  (resetN),
    .restart (startNote),
    .tick    (tick)
  );

  always_comb begin
    enMask = '0;
    for (int i = 0; i < NUM_EVENTS; i++) enMask[i] = (NOTE_CNT[i] != '0);
    cand    = (pending | event_req) & enMask;
    anyCand = |cand;
    best    = '0;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) if (cand[i]) best = EVT_W'(i);
    bestOh   = NUM_EVENTS'(1) << best;
    actOh    = NUM_EVENTS'(1) << activeEvt;
    lastNote = (NCNT_W'(noteIdx) + NCNT_W'(1)) >= NOTE_CNT[activeEvt];
  end

  always_comb begin
    stateN     = state;
    activeEvtN = activeEvt;
    noteIdxN   = noteIdx;
    durCntN    = durCnt;
    gapCntN    = gapCnt;
    pendingN   = pending;
    prescaleN  = prescale;
    playQN     = playQ;
    busyQN     = busyQ;
    startNote  = 1'b0;
    startEvt   = best;
    startIdx   = '0;

    if (state == IDLE) begin
      if (anyCand) begin
        startNote = 1'b1;
        pendingN  = cand & ~bestOh;
      end
    end else if (anyCand && (best < activeEvt)) begin
      // Preemption drops the interrupted event entirely.
      startNote = 1'b1;
      pendingN  = cand & ~bestOh & ~actOh;
    end else begin
      pendingN = (pending | (event_req & enMask)) & ~actOh;
      startEvt = activeEvt;
      if ((RETRIGGER != 0) && event_req[activeEvt]) begin
        startNote = 1'b1;
      end else if (state == PLAY) begin
        if (tick) begin
          if (durCnt <= DUR_W'(1)) begin
            if (lastNote) begin
              stateN = IDLE;
              playQN = 1'b0;
              busyQN = 1'b0;
            end else if (GAP_CYCLES > 0) begin
              stateN  = GAP;
              gapCntN = GAP_W'(GAP_CYCLES - 1);
              playQN  = 1'b0;
            end else begin
              startNote = 1'b1;
              startIdx  = noteIdx + IDX_W'(1);
            end
          end else begin
            durCntN = durCnt - DUR_W'(1);
          end
        end
      end else if (gapCnt == '0) begin
        startNote = 1'b1;
        startIdx  = noteIdx + IDX_W'(1);
      end else begin
        gapCntN = gapCnt - GAP_W'(1);
      end
    end

    if (startNote) begin
      stateN     = PLAY;
      activeEvtN = startEvt;
      noteIdxN   = startIdx;
      prescaleN  = PRESCALE_W'(NOTE_TABLE[startEvt][startIdx].prescale);
      durCntN    = DUR_W'(noteTicks(NOTE_TABLE[startEvt][startIdx]));
      playQN     = 1'b1;
      busyQN     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      activeEvt <= '0;
      noteIdx   <= '0;
      durCnt    <= '0;
      gapCnt    <= '0;
      pending   <= '0;
      prescale  <= '0;
      playQ     <= 1'b0;
      busyQ     <= 1'b0;
    end else begin
      state     <= stateN;
      activeEvt <= activeEvtN;
      noteIdx   <= noteIdxN;
      durCnt    <= durCntN;
      gapCnt    <= gapCntN;
      pending   <= pendingN;
      prescale  <= prescaleN;
      playQ     <= playQN;
      busyQ     <= busyQN;
    end
  end

  assign enable_sound    = playQ & ~mute;
  assign pre_scale_value = prescale;
  assign active_event    = activeEvt;
  assign busy            = busyQ;

endmodule
